// File: rtl/timestep_sched_if.sv
// Bundles the run/done/clear controls and the scheduler status outputs.
interface timestep_sched_if;
   logic        run;
   logic        done;
   logic        clr_ovr;
   logic        trig;
   logic        busy;
   logic        overrun;
   logic [31:0] step_cnt;
   logic [15:0] skip_cnt;

   // Controller side: drives the controls and observes the status.
   modport master (
      output run, done, clr_ovr,
      input  trig, busy, overrun, step_cnt, skip_cnt
   );

   // Scheduler side.
   modport slave (
      input  run, done, clr_ovr,
      output trig, busy, overrun, step_cnt, skip_cnt
   );
endinterface

// File: rtl/timestep_sched.sv
// Timestep scheduler: after an optional alignment delay it raises a one-cycle
// trig every PERIOD cycles, but only while the solver chain is free.
// A trigger that falls due while the chain is still busy is skipped and flagged.
module timestep_sched #(
   parameter int unsigned PERIOD = 32'd1000,
   parameter int unsigned OFFSET = 32'd0
) (
   input logic             clk,
   input logic             rst,
   timestep_sched_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StAlign, StRun} state_e;

   localparam logic [31:0] PeriodM1 = 32'(PERIOD - 1);
   localparam logic [31:0] OffsetM1 = (OFFSET == 0) ? 32'd0 : 32'(OFFSET - 1);

   state_e      state_q, state_d;
   logic [31:0] tc_q, tc_d;
   logic [31:0] ocnt_q, ocnt_d;
   logic        trig_q, trig_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
   logic [31:0] step_q, step_d;
   logic [15:0] skip_q, skip_d;
   logic        due;
   logic        eff_busy;

   // done in the same cycle as a due trigger frees the slot for that trigger.
   assign eff_busy = busy_q & ~bus.done;

   // Next-state: sequencing FSM plus trigger/busy/overrun bookkeeping.
   always_comb begin
      state_d   = state_q;
      tc_d      = tc_q;
      ocnt_d    = ocnt_q;
      trig_d    = 1'b0;
      busy_d    = busy_q;
      overrun_d = overrun_q;
      step_d    = step_q;
      skip_d    = skip_q;
      due       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.run) begin
               if (OFFSET == 0) begin
                  state_d = StRun;
                  tc_d    = 32'd0;
               end else begin
                  state_d = StAlign;
                  ocnt_d  = 32'd0;
               end
            end
         end
         StAlign: begin
            if (!bus.run) begin
               state_d = StIdle;
               tc_d    = 32'd0;
               ocnt_d  = 32'd0;
            end else if (ocnt_q == OffsetM1) begin
               state_d = StRun;
               tc_d    = 32'd0;
               ocnt_d  = 32'd0;
            end else begin
               ocnt_d = ocnt_q + 32'd1;
            end
         end
         StRun: begin
            if (!bus.run) begin
               state_d = StIdle;
               tc_d    = 32'd0;
               ocnt_d  = 32'd0;
            end else begin
               due  = (tc_q == 32'd0);
               tc_d = (tc_q == PeriodM1) ? 32'd0 : tc_q + 32'd1;
            end
         end
         default: begin
            state_d = StIdle;
            tc_d    = 32'd0;
            ocnt_d  = 32'd0;
         end
      endcase

      // Clear first so a simultaneous new overrun wins.
      if (bus.clr_ovr) begin
         overrun_d = 1'b0;
      end

      if (due) begin
         if (!eff_busy) begin
            trig_d = 1'b1;
            busy_d = 1'b1;
            step_d = step_q + 32'd1;
         end else begin
            overrun_d = 1'b1;
            if (skip_q != 16'hFFFF) begin
               skip_d = skip_q + 16'd1;
            end
         end
      end else if (bus.done && busy_q) begin
         busy_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         tc_q      <= 32'd0;
         ocnt_q    <= 32'd0;
         trig_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         step_q    <= 32'd0;
         skip_q    <= 16'd0;
      end else begin
         state_q   <= state_d;
         tc_q      <= tc_d;
         ocnt_q    <= ocnt_d;
         trig_q    <= trig_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         step_q    <= step_d;
         skip_q    <= skip_d;
      end
   end

   assign bus.trig     = trig_q;
   assign bus.busy     = busy_q;
   assign bus.overrun  = overrun_q;
   assign bus.step_cnt = step_q;
   assign bus.skip_cnt = skip_q;

endmodule

// File: tb/tb_timestep_sched.sv
// Directed bench: dut_a uses PERIOD=4/OFFSET=0, dut_b PERIOD=4/OFFSET=3.
module tb_timestep_sched;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   timestep_sched_if a_if ();
   timestep_sched_if b_if ();

   timestep_sched #(.PERIOD(32'd4), .OFFSET(32'd0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   timestep_sched #(.PERIOD(32'd4), .OFFSET(32'd3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag, input logic [31:0] trig, input logic [31:0] busy,
                               input logic [31:0] ovr, input logic [31:0] stp,
                               input logic [31:0] skp);
      chk({tag, ".trig"}, trig, 32'd0);
      chk({tag, ".busy"}, busy, 32'd0);
      chk({tag, ".overrun"}, ovr, 32'd0);
      chk({tag, ".step_cnt"}, stp, 32'd0);
      chk({tag, ".skip_cnt"}, skp, 32'd0);
   endtask

   initial begin
      a_if.run = 1'b0; a_if.done = 1'b0; a_if.clr_ovr = 1'b0;
      b_if.run = 1'b0; b_if.done = 1'b0; b_if.clr_ovr = 1'b0;

      // Reset state
      #12;
      chk_all_zero("rst_a", 32'(a_if.trig), 32'(a_if.busy), 32'(a_if.overrun), a_if.step_cnt,
                   32'(a_if.skip_cnt));
      chk_all_zero("rst_b", 32'(b_if.trig), 32'(b_if.busy), 32'(b_if.overrun), b_if.step_cnt,
                   32'(b_if.skip_cnt));
      rst = 1'b1;
      a_if.run = 1'b1;
      b_if.run = 1'b1;

      // Nominal cadence with done returned after each trig; dut_b aligned by 3
      step(); // edge 0
      chk("s1.e0.a_trig", 32'(a_if.trig), 32'd0);
      step(); // edge 1
      chk("s1.e1.a_trig", 32'(a_if.trig), 32'd1);
      chk("s1.e1.a_step", a_if.step_cnt, 32'd1);
      chk("s1.e1.a_busy", 32'(a_if.busy), 32'd1);
      chk("s1.e1.b_trig", 32'(b_if.trig), 32'd0);
      step(); // edge 2
      chk("s1.e2.a_trig", 32'(a_if.trig), 32'd0);
      a_if.done = 1'b1;
      step(); // edge 3
      a_if.done = 1'b0;
      chk("s1.e3.a_busy", 32'(a_if.busy), 32'd0);
      chk("s1.e3.b_trig", 32'(b_if.trig), 32'd0);
      step(); // edge 4
      chk("s1.e4.b_trig", 32'(b_if.trig), 32'd1);
      chk("s1.e4.a_trig", 32'(a_if.trig), 32'd0);
      b_if.done = 1'b1;
      step(); // edge 5
      b_if.done = 1'b0;
      chk("s1.e5.a_trig", 32'(a_if.trig), 32'd1);
      chk("s1.e5.a_step", a_if.step_cnt, 32'd2);
      chk("s1.e5.b_trig", 32'(b_if.trig), 32'd0);
      chk("s1.e5.b_busy", 32'(b_if.busy), 32'd0);
      a_if.done = 1'b1;
      step(); // edge 6
      a_if.done = 1'b0;
      chk("s1.e6.a_busy", 32'(a_if.busy), 32'd0);
      step(); // edge 7
      chk("s1.e7.a_trig", 32'(a_if.trig), 32'd0);
      step(); // edge 8
      chk("s1.e8.b_trig", 32'(b_if.trig), 32'd1);
      chk("s1.e8.b_step", b_if.step_cnt, 32'd2);
      chk("s1.e8.b_ovr", 32'(b_if.overrun), 32'd0);
      step(); // edge 9
      chk("s1.e9.a_trig", 32'(a_if.trig), 32'd1);
      chk("s1.e9.a_step", a_if.step_cnt, 32'd3);
      chk("s1.e9.a_ovr", 32'(a_if.overrun), 32'd0);
      chk("s1.e9.a_busy", 32'(a_if.busy), 32'd1);

      // Asynchronous reset between edges while busy
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero("arst_a", 32'(a_if.trig), 32'(a_if.busy), 32'(a_if.overrun), a_if.step_cnt,
                   32'(a_if.skip_cnt));
      a_if.run = 1'b0;
      b_if.run = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      chk("arst.post_rel_trig", 32'(a_if.trig), 32'd0);

      // Overruns with done never returned
      a_if.run = 1'b1;
      step(); // edge 0
      chk("s2.e0.trig", 32'(a_if.trig), 32'd0);
      step(); // edge 1
      chk("s2.e1.trig", 32'(a_if.trig), 32'd1);
      chk("s2.e1.step", a_if.step_cnt, 32'd1);
      for (int i = 2; i <= 4; i++) begin
         step();
         chk("s2.gap.trig", 32'(a_if.trig), 32'd0);
      end
      step(); // edge 5
      chk("s2.e5.trig", 32'(a_if.trig), 32'd0);
      chk("s2.e5.ovr", 32'(a_if.overrun), 32'd1);
      chk("s2.e5.skip", 32'(a_if.skip_cnt), 32'd1);
      chk("s2.e5.step", a_if.step_cnt, 32'd1);
      repeat (4) step(); // edge 9
      chk("s2.e9.trig", 32'(a_if.trig), 32'd0);
      chk("s2.e9.skip", 32'(a_if.skip_cnt), 32'd2);
      chk("s2.e9.step", a_if.step_cnt, 32'd1);
      repeat (3) step(); // edge 12
      a_if.clr_ovr = 1'b1;
      step(); // edge 13: new overrun beats the clear
      chk("s2.e13.ovr_set_wins", 32'(a_if.overrun), 32'd1);
      chk("s2.e13.skip", 32'(a_if.skip_cnt), 32'd3);
      step(); // edge 14: plain clear
      a_if.clr_ovr = 1'b0;
      chk("s2.e14.ovr_clr", 32'(a_if.overrun), 32'd0);
      repeat (2) step(); // edge 16
      a_if.done = 1'b1;

      // done on the due edge frees the slot
      step(); // edge 17
      chk("s3.e17.trig", 32'(a_if.trig), 32'd1);
      chk("s3.e17.busy", 32'(a_if.busy), 32'd1);
      chk("s3.e17.ovr", 32'(a_if.overrun), 32'd0);
      chk("s3.e17.step", a_if.step_cnt, 32'd2);
      chk("s3.e17.skip", 32'(a_if.skip_cnt), 32'd3);
      step(); // edge 18: done again, nothing due, busy clears
      a_if.done = 1'b0;
      chk("s3.e18.busy", 32'(a_if.busy), 32'd0);
      a_if.run = 1'b0;

      // run dropped two cycles after the trig
      step(); // edge 19
      chk("s4.e19.trig", 32'(a_if.trig), 32'd0);
      a_if.done = 1'b1;
      step(); // edge 20: stray done while idle and not busy
      a_if.done = 1'b0;
      chk("s4.e20.busy", 32'(a_if.busy), 32'd0);
      chk("s4.e20.step", a_if.step_cnt, 32'd2);
      step(); // edge 21 would have been due
      chk("s4.e21.trig", 32'(a_if.trig), 32'd0);
      step();
      chk("s4.e22.trig", 32'(a_if.trig), 32'd0);
      chk("s4.e22.skip", 32'(a_if.skip_cnt), 32'd3);
      a_if.run = 1'b1;
      step(); // restart edge 0
      chk("s4.r0.trig", 32'(a_if.trig), 32'd0);
      step(); // restart edge 1
      chk("s4.r1.trig", 32'(a_if.trig), 32'd1);
      chk("s4.r1.step", a_if.step_cnt, 32'd3);
      chk("s4.r1.busy", 32'(a_if.busy), 32'd1);
      step();
      chk("s4.r2.trig", 32'(a_if.trig), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/timestep_sched.md
TIMESTEP_SCHED -- requirements
Module: timestep_sched

Interface
REQ-001 The block SHALL have parameter PERIOD, default 32'd1000, giving the simulation timestep length in clk cycles; legal range 2..2^32-1.
REQ-002 The block SHALL have parameter OFFSET, default 32'd0, giving the extra delay in clk cycles from run start to the first trigger.
REQ-003 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous and active-low (0 = reset asserted).
REQ-005 Port run  input  1  level enable; 1 = schedule timesteps, 0 = stop.
REQ-006 Port done  input  1  single-cycle pulse from the downstream solver chain marking completion of the current timestep.
REQ-007 Port clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-008 Port trig  output  1  registered single-cycle timestep start pulse; feeds the trigger input of the enable-stretch stage.
REQ-009 Port busy  output  1  registered; 1 from an issued trig until the matching done.
REQ-010 Port overrun  output  1  registered sticky flag; a trigger was due while busy=1.
REQ-011 Port step_cnt  output  32  registered count of issued triggers.
REQ-012 Port skip_cnt  output  16  registered count of suppressed triggers.

Function
REQ-013 The block SHALL implement the states IDLE, ALIGN and RUN.
REQ-014 IDLE: on an edge with run=1, if OFFSET=0 the state SHALL go to RUN with tc=0; otherwise it SHALL go to ALIGN with ocnt=0.
REQ-015 ALIGN: ocnt SHALL increment each cycle; when ocnt=OFFSET-1 the state SHALL go to RUN with tc=0.
REQ-016 RUN: a trigger SHALL be due on each edge where tc=0; tc SHALL count 0..PERIOD-1 and then wrap to 0.
REQ-017 The first trig SHALL be high during the cycle following edge OFFSET+1, where edge 0 is the first edge sampling run=1; later trigs SHALL be exactly PERIOD cycles apart.
REQ-018 A due trigger with effective busy=0 SHALL assert trig for exactly one cycle, set busy, and increment step_cnt.
REQ-019 step_cnt SHALL wrap from 32'hFFFFFFFF to 0.
REQ-020 A due trigger with effective busy=1 SHALL keep trig low, set overrun, and increment skip_cnt.
REQ-021 skip_cnt SHALL saturate at 16'hFFFF.
REQ-022 Effective busy = busy AND NOT done: done in the same cycle as a due trigger SHALL free the slot, so trig is issued and busy stays 1.
REQ-023 done with busy=0 SHALL be ignored, with no state change.
REQ-024 done SHALL clear busy on the following edge when no trigger is issued in that cycle.
REQ-025 overrun SHALL clear only on clr_ovr=1 or reset.
REQ-026 If clr_ovr=1 and a new overrun occur in the same cycle, the set SHALL win (overrun=1).
REQ-027 run=0 sampled in ALIGN or RUN SHALL return the state to IDLE on that edge, clear tc and ocnt, and issue no trig on that edge.
REQ-028 run=0 SHALL NOT change busy, step_cnt, skip_cnt or overrun.
REQ-029 Re-asserting run SHALL restart alignment from REQ-014.
REQ-030 trig SHALL never be high on two consecutive cycles.

Reset
REQ-031 While rst=0 the block SHALL force state=IDLE and tc=ocnt=0, independent of clk.
REQ-032 While rst=0 the outputs SHALL be trig=0, busy=0, overrun=0, step_cnt=0 and skip_cnt=0.
REQ-033 Reset asserted mid-operation SHALL abort immediately, with no residual trig after release.
REQ-034 After rst rises, the block SHALL wait in IDLE for run as in REQ-014.

Verification
REQ-035 PERIOD=4, OFFSET=0; run=1 from edge 0; done pulsed 1 cycle after each trig -> trig high after edges 1, 5, 9; step_cnt=3 after edge 9; overrun=0.
REQ-036 PERIOD=4, OFFSET=3; run=1 from edge 0 -> first trig high after edge 4, next after edge 8.
REQ-037 PERIOD=4; done never pulsed -> trig after edge 1 only; overrun=1 after edge 5; skip_cnt=1 after edge 5 and 2 after edge 9; step_cnt stays 1.
REQ-038 PERIOD=4; done pulsed exactly on the edge a trigger is due -> trig issued, busy stays 1, overrun=0; clr_ovr pulsed on an overrun edge -> overrun=1.
REQ-039 Drop run to 0 two cycles after a trig, then raise it again -> no trig while run=0; first new trig OFFSET+1 edges after run is re-sampled; step_cnt continues counting.
REQ-040 Assert rst=0 asynchronously between edges while busy=1 -> all outputs 0 immediately; no trig until run is sampled after release.
